// File: rtl/jpc_imem_fetch_if.sv
// Bundle between the fetch controller, its clients (boot loader, decode) and the BRAM port.
// Latency: none, wires only. master = fetch controller side, slave = environment side.
// Backpressure: ld_valid/ld_ready for loader writes, inst_valid/inst_ready toward decode.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

interface jpc_imem_fetch_if #(
  parameter int W = `JPC_ADDRESS_WIDTH
);
  // control
  logic         start;
  logic [W-1:0] start_pc;
  logic         halt;
  // loader
  logic         ld_valid;
  logic         ld_ready;
  logic [W-1:0] ld_addr;
  logic [W-1:0] ld_data;
  // redirect
  logic         redir_valid;
  logic [W-1:0] redir_pc;
  // decode stream
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst_data;
  logic [W-1:0] inst_pc;
  logic         busy;
  // BRAM port
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_din;
  logic         mem_we;
  logic [W-1:0] mem_dout;

  modport master (
    input  start, start_pc, halt,
    input  ld_valid, ld_addr, ld_data,
    input  redir_valid, redir_pc,
    input  inst_ready, mem_dout,
    output ld_ready, inst_valid, inst_data, inst_pc, busy,
    output mem_addr, mem_din, mem_we
  );

  modport slave (
    output start, start_pc, halt,
    output ld_valid, ld_addr, ld_data,
    output redir_valid, redir_pc,
    output inst_ready, mem_dout,
    input  ld_ready, inst_valid, inst_data, inst_pc, busy,
    input  mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/jpc_imem_fetch.sv
// Instruction BRAM requester: program loader while idle, instruction streamer while running.
// Latency: first instruction 1 cycle after start/redirect; then 1 instruction per cycle.
// Backpressure: inst_ready low re-reads the held address so inst_data stays stable; ld_ready low when start or running.
// Optional macro JPC_FETCH_PERF_EN adds perf_fetched / perf_stall saturating counters.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_imem_fetch #(
  parameter int DEPTH = 256  // power of two
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jpc_imem_fetch_if.master      bus
`ifdef JPC_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam int W  = `JPC_ADDRESS_WIDTH;
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic          r_inst_valid;
  logic [AW-1:0] r_inst_pc;

  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [W-1:0]  w_din;
  logic          w_ld_ready;
  logic          w_fire;
  logic          w_start_acc;

  // Upper address bits are discarded by design; gathered here to document that.
  wire w_unused = ^{bus.start_pc[W-1:AW], bus.ld_addr[W-1:AW], bus.redir_pc[W-1:AW]};

  assign w_fire      = r_inst_valid & bus.inst_ready;
  assign w_start_acc = (r_state == S_IDLE) & bus.start;

  // BRAM request: loader writes in IDLE (start wins), next fetch address in RUN.
  always_comb begin
    w_addr     = r_inst_pc;
    w_we       = 1'b0;
    w_din      = '0;
    w_ld_ready = 1'b0;
    if (r_state == S_IDLE) begin
      w_ld_ready = !bus.start;
      w_din      = bus.ld_data;
      if (bus.start) begin
        w_addr = bus.start_pc[AW-1:0];
      end else begin
        w_addr = bus.ld_addr[AW-1:0];
        w_we   = bus.ld_valid;
      end
    end else begin
      if (bus.halt) begin
        w_addr = '0;
      end else if (bus.redir_valid) begin
        w_addr = bus.redir_pc[AW-1:0];
      end else if (w_fire) begin
        w_addr = r_inst_pc + 1'b1;  // wraps at DEPTH
      end else begin
        w_addr = r_inst_pc;         // stall: re-read so dout holds
      end
    end
  end

  assign bus.mem_addr   = {{(W-AW){1'b0}}, w_addr};
  assign bus.mem_we     = w_we;
  assign bus.mem_din    = w_din;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_pc    = {{(W-AW){1'b0}}, r_inst_pc};
  assign bus.inst_data  = r_inst_valid ? bus.mem_dout : '0;
  assign bus.busy       = (r_state == S_RUN);

  // State, presented PC and valid: the registered PC always tracks the address sent to the BRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_RUN;
            r_inst_pc    <= w_addr;
            r_inst_valid <= 1'b1;
          end
        end
        default: begin
          if (bus.halt) begin
            r_state      <= S_IDLE;
            r_inst_valid <= 1'b0;
          end else begin
            r_inst_pc    <= w_addr;
            r_inst_valid <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef JPC_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Saturating fire / stall counters, cleared when a new run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else if (w_start_acc) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_fire && (r_perf_fetched != 32'hFFFF_FFFF))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_inst_valid && !bus.inst_ready && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  wire w_unused_start = w_start_acc;
`endif

endmodule

// File: tb/tb_jpc_imem_fetch.sv
// Bench for jpc_imem_fetch: directed vector table, reset corner cases, then random traffic
// checked against an abstract model (running flag, current PC, shadow copy of memory).
// The BRAM itself is modelled here: 1-cycle synchronous read, read-during-write returns old data.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module tb_jpc_imem_fetch;

  localparam int W     = `JPC_ADDRESS_WIDTH;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  typedef logic [W-1:0] word_t;
  localparam word_t MASK = word_t'(DEPTH - 1);

  typedef struct packed {
    logic  start; word_t spc; logic hlt;
    logic  ldv;   word_t lda; word_t ldd;
    logic  rdv;   word_t rpc; logic rdy;
    logic  e_v;   word_t e_pc; word_t e_dat;
    logic  e_ldr; logic e_we; word_t e_addr; logic e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jpc_imem_fetch_if #(.W(W)) bus();

`ifdef JPC_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  jpc_imem_fetch #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                       .perf_fetched(perf_fetched), .perf_stall(perf_stall));
`else
  jpc_imem_fetch #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // BRAM model
  bit [W-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_addr[AW-1:0]] <= bus.mem_din;
    bus.mem_dout <= bram[bus.mem_addr[AW-1:0]];
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: abstract fetch state plus shadow of what memory should hold.
  bit [W-1:0] ref_mem [DEPTH];
  bit          m_run;
  bit          m_valid;
  int          m_pc;
  longint      m_fet, m_stl;

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_pc = 0; m_fet = 0; m_stl = 0;
  endtask

  task automatic model_check(input vec_t v);
    word_t ea;
    if (!m_run)              ea = v.start ? (v.spc & MASK) : (v.lda & MASK);
    else if (v.hlt)          ea = '0;
    else if (v.rdv)          ea = v.rpc & MASK;
    else if (m_valid && v.rdy) ea = word_t'((m_pc + 1) % DEPTH);
    else                     ea = word_t'(m_pc);
    chk1("ld_ready", bus.ld_ready, !m_run && !v.start);
    chk1("mem_we", bus.mem_we, !m_run && !v.start && v.ldv);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_din", bus.mem_din, m_run ? word_t'(0) : v.ldd);
    chk1("busy", bus.busy, m_run);
    chk1("inst_valid", bus.inst_valid, m_valid);
    chk("inst_data", bus.inst_data, m_valid ? word_t'(ref_mem[m_pc]) : word_t'(0));
    if (m_valid) chk("inst_pc", bus.inst_pc, word_t'(m_pc));
`ifdef JPC_FETCH_PERF_EN
    chk("perf_fetched", word_t'(perf_fetched), word_t'(m_fet));
    chk("perf_stall", word_t'(perf_stall), word_t'(m_stl));
`endif
  endtask

  task automatic model_update(input vec_t v);
    if (!m_run) begin
      if (v.start) begin
        m_run = 1; m_valid = 1; m_pc = int'(v.spc & MASK); m_fet = 0; m_stl = 0;
      end else if (v.ldv) begin
        ref_mem[int'(v.lda & MASK)] = v.ldd;
      end
    end else begin
      if (m_valid &&  v.rdy && m_fet < 64'hFFFF_FFFF) m_fet++;
      if (m_valid && !v.rdy && m_stl < 64'hFFFF_FFFF) m_stl++;
      if (v.hlt) begin
        m_run = 0; m_valid = 0;
      end else if (v.rdv) begin
        m_pc = int'(v.rpc & MASK); m_valid = 1;
      end else if (v.rdy) begin
        m_pc = (m_pc + 1) % DEPTH; m_valid = 1;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    bus.start = v.start; bus.start_pc = v.spc; bus.halt = v.hlt;
    bus.ld_valid = v.ldv; bus.ld_addr = v.lda; bus.ld_data = v.ldd;
    bus.redir_valid = v.rdv; bus.redir_pc = v.rpc; bus.inst_ready = v.rdy;
  endtask

  // One cycle: entered 1 time unit after a rising edge.
  task automatic step(input vec_t v, input bit use_table);
    drive(v);
    @(negedge clk);
    if (use_table) begin
      chk1("tbl ld_ready", bus.ld_ready, v.e_ldr);
      chk1("tbl mem_we", bus.mem_we, v.e_we);
      chk("tbl mem_addr", bus.mem_addr, v.e_addr);
      chk1("tbl busy", bus.busy, v.e_busy);
      chk1("tbl inst_valid", bus.inst_valid, v.e_v);
      chk("tbl inst_data", bus.inst_data, v.e_dat);
      if (v.e_v) chk("tbl inst_pc", bus.inst_pc, v.e_pc);
    end else begin
      model_check(v);
    end
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  function automatic vec_t mk(logic st, word_t spc, logic hlt, logic ldv, word_t lda, word_t ldd,
                              logic rdv, word_t rpc, logic rdy,
                              logic ev, word_t epc, word_t edat, logic eldr, logic ewe,
                              word_t eaddr, logic ebusy);
    vec_t v;
    v.start = st; v.spc = spc; v.hlt = hlt; v.ldv = ldv; v.lda = lda; v.ldd = ldd;
    v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
    v.e_v = ev; v.e_pc = epc; v.e_dat = edat; v.e_ldr = eldr; v.e_we = ewe;
    v.e_addr = eaddr; v.e_busy = ebusy;
    return v;
  endfunction

  function automatic word_t rnd_addr();
    return ($urandom & 32'hFFFF_FF00) | word_t'($urandom_range(0, 31));
  endfunction

  vec_t tbl [24];
  vec_t rv;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           st spc     h ld lda     ldd     rd rpc  rdy | v pc     dat     ldr we addr   busy
    tbl[0]  = mk(0, 0,      0, 1, 'h0,   'h10,   0, 0,   0,   0, 0,     0,      1,  1, 'h0,  0);
    tbl[1]  = mk(0, 0,      0, 1, 'h1,   'h11,   0, 0,   0,   0, 0,     0,      1,  1, 'h1,  0);
    tbl[2]  = mk(0, 0,      0, 1, 'h2,   'h12,   0, 0,   0,   0, 0,     0,      1,  1, 'h2,  0);
    tbl[3]  = mk(0, 0,      0, 1, 'h3,   'h13,   0, 0,   0,   0, 0,     0,      1,  1, 'h3,  0);
    tbl[4]  = mk(0, 0,      0, 1, 'h1FF, 'h55,   0, 0,   0,   0, 0,     0,      1,  1, 'hFF, 0);
    tbl[5]  = mk(1, 0,      0, 0, 0,     0,      0, 0,   1,   0, 0,     0,      0,  0, 'h0,  0);
    tbl[6]  = mk(0, 0,      0, 0, 0,     0,      0, 0,   1,   1, 'h0,   'h10,   0,  0, 'h1,  1);
    tbl[7]  = mk(0, 0,      0, 0, 0,     0,      0, 0,   1,   1, 'h1,   'h11,   0,  0, 'h2,  1);
    tbl[8]  = mk(0, 0,      0, 0, 0,     0,      0, 0,   0,   1, 'h2,   'h12,   0,  0, 'h2,  1);
    tbl[9]  = mk(0, 0,      0, 0, 0,     0,      0, 0,   0,   1, 'h2,   'h12,   0,  0, 'h2,  1);
    tbl[10] = mk(0, 0,      0, 0, 0,     0,      0, 0,   0,   1, 'h2,   'h12,   0,  0, 'h2,  1);
    tbl[11] = mk(0, 0,      0, 0, 0,     0,      0, 0,   1,   1, 'h2,   'h12,   0,  0, 'h3,  1);
    tbl[12] = mk(0, 0,      0, 0, 0,     0,      1, 'h1, 1,   1, 'h3,   'h13,   0,  0, 'h1,  1);
    tbl[13] = mk(0, 0,      0, 0, 0,     0,      0, 0,   1,   1, 'h1,   'h11,   0,  0, 'h2,  1);
    tbl[14] = mk(0, 0,      0, 0, 0,     0,      0, 0,   1,   1, 'h2,   'h12,   0,  0, 'h3,  1);
    tbl[15] = mk(0, 0,      1, 0, 0,     0,      0, 0,   1,   1, 'h3,   'h13,   0,  0, 'h0,  1);
    tbl[16] = mk(1, 'h1FF,  0, 1, 'h5,   'hAA,   0, 0,   0,   0, 0,     0,      0,  0, 'hFF, 0);
    tbl[17] = mk(0, 0,      0, 0, 0,     0,      0, 0,   1,   1, 'hFF,  'h55,   0,  0, 'h0,  1);
    tbl[18] = mk(0, 0,      1, 0, 0,     0,      0, 0,   1,   1, 'h0,   'h10,   0,  0, 'h0,  1);
    tbl[19] = mk(0, 0,      0, 0, 0,     0,      0, 0,   0,   0, 0,     0,      1,  0, 'h0,  0);
    tbl[20] = mk(1, 'h5,    0, 0, 0,     0,      0, 0,   0,   0, 0,     0,      0,  0, 'h5,  0);
    tbl[21] = mk(0, 0,      1, 0, 0,     0,      0, 0,   0,   1, 'h5,   0,      0,  0, 'h0,  1);
    tbl[22] = mk(0, 0,      1, 0, 'h9,   0,      1, 'h7, 0,   0, 0,     0,      1,  0, 'h9,  0);
    tbl[23] = mk(0, 0,      0, 0, 0,     0,      0, 0,   0,   0, 0,     0,      1,  0, 'h0,  0);

    // Reset state
    rst_n = 1'b0;
    model_reset();
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    chk1("reset inst_valid", bus.inst_valid, 1'b0);
    chk("reset inst_pc", bus.inst_pc, '0);
    chk1("reset busy", bus.busy, 1'b0);
    chk("reset inst_data", bus.inst_data, '0);
`ifdef JPC_FETCH_PERF_EN
    chk("reset perf_fetched", word_t'(perf_fetched), '0);
    chk("reset perf_stall", word_t'(perf_stall), '0);
`endif
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 24; i++) step(tbl[i], 1'b1);

    // Reset in the middle of a run
    rv = '0; rv.start = 1'b1; rv.spc = 'h2;
    step(rv, 1'b0);
    rv = '0; rv.rdy = 1'b1;
    for (int i = 0; i < 3; i++) step(rv, 1'b0);
    rv = '0;
    drive(rv);
    #2 rst_n = 1'b0;
    #1;
    chk1("async rst inst_valid", bus.inst_valid, 1'b0);
    chk1("async rst busy", bus.busy, 1'b0);
    chk1("async rst ld_ready", bus.ld_ready, 1'b1);
`ifdef JPC_FETCH_PERF_EN
    chk("async rst perf_fetched", word_t'(perf_fetched), '0);
    chk("async rst perf_stall", word_t'(perf_stall), '0);
`endif
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rv       = '0;
      rv.start = ($urandom_range(0, 7) == 0);
      rv.spc   = rnd_addr();
      rv.hlt   = ($urandom_range(0, 15) == 0);
      rv.ldv   = 1'($urandom_range(0, 1));
      rv.lda   = rnd_addr();
      rv.ldd   = $urandom;
      rv.rdv   = ($urandom_range(0, 7) == 0);
      rv.rpc   = rnd_addr();
      rv.rdy   = ($urandom_range(0, 3) != 0);
      step(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
